// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the configurable UART transmitter
//
// Purpose : parity encodings, one-hot FSM state encodings and a clog2 helper
//           used to size counters from elaboration-time parameters.
// Ports   : none (package).
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_e;

   // One-hot encoding, kept compatible with the earlier fixed-format transmitter.
   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_START  = 6'b000010,
      S_DATA   = 6'b000100,
      S_PARITY = 6'b001000,
      S_STOP   = 6'b010000,
      S_BREAK  = 6'b100000
   } state_e;

   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - source/line-side signal bundle of the UART transmitter
//
// Purpose : groups the oversample tick, the ready/valid word handshake with
//           its per-frame options, and the serial line outputs.
// Ports   : i_tick, i_valid, i_data[NB_DATA], i_parity[2], i_stop2, i_break
//           (source -> transmitter); o_ready, o_data, o_done
//           (transmitter -> source/pin).
// Modports: master = data source / tick generator side, slave = transmitter.
interface uart_tx_cfg_if #(
   parameter int NB_DATA = 8
);
   logic               i_tick;
   logic               i_valid;
   logic               o_ready;
   logic [NB_DATA-1:0] i_data;
   logic [1:0]         i_parity;
   logic               i_stop2;
   logic               i_break;
   logic               o_data;
   logic               o_done;

   modport master (
      output i_tick, i_valid, i_data, i_parity, i_stop2, i_break,
      input  o_ready, o_data, o_done
   );

   modport slave (
      input  i_tick, i_valid, i_data, i_parity, i_stop2, i_break,
      output o_ready, o_data, o_done
   );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - oversample tick counter producing bit-period end strobes
//
// Purpose : counts tick pulses from 0 up to 'last' and flags the tick that
//           completes the period; wraps to 0 on that tick so consecutive
//           periods never drift.
// Ports   : clk, reset (sync, active high), tick (oversample strobe),
//           clear (force count to 0), last (final count of the period),
//           bit_end (combinational one-cycle strobe on the closing tick).
module uart_bit_timer #(
   parameter int NB_TCNT = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               clear,
   input  logic [NB_TCNT-1:0] last,
   output logic               bit_end
);
   logic [NB_TCNT-1:0] cnt;

   assign bit_end = tick && (cnt == last);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= bit_end ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with per-frame parity/stop options
//
// Purpose : serialises NB_DATA-bit words LSB first as start, data, optional
//           parity and one or two stop bits, each bit OVERSAMPLE ticks long.
// Ports   : i_clk, i_reset (sync, active high); bus (uart_tx_cfg_if.slave):
//           tick/valid/data/parity/stop2/break in, ready/line/done out.
// Options : define UART_TX_BREAK_EN to build the line-break state.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int NB_DATA    = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic           i_clk,
   input  logic           i_reset,
   uart_tx_cfg_if.slave   bus
);
   localparam int NB_TCNT = clog2(2 * OVERSAMPLE);
   localparam int NB_IDX  = clog2(NB_DATA);
   localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(NB_DATA - 1);
   localparam logic [NB_TCNT-1:0] LAST_1   = NB_TCNT'(OVERSAMPLE - 1);
   localparam logic [NB_TCNT-1:0] LAST_2   = NB_TCNT'(2 * OVERSAMPLE - 1);

   state_e             st, st_next;
   logic [NB_IDX-1:0]  idx, idx_next;
   logic [NB_DATA-1:0] data_q;
   parity_e            par_q;
   logic               stop2_q;
   logic               line, line_next;
   logic               accept, done;
   logic               bit_end, tmr_clear;
   logic [NB_TCNT-1:0] tmr_last;
   logic               brk_req, brk_stop;
   logic               par_en, par_bit;

   assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign par_bit = (^data_q) ^ (par_q == PAR_ODD);

`ifdef UART_TX_BREAK_EN
   localparam int NB_BCNT     = clog2(OVERSAMPLE * (NB_DATA + 3) + 1);
   localparam int BREAK_TICKS = OVERSAMPLE * (NB_DATA + 3);

   logic [NB_BCNT-1:0] brk_cnt;
   logic               brk_full;
   logic               brk_flag;

   assign brk_req  = bus.i_break;
   assign brk_full = (brk_cnt == NB_BCNT'(BREAK_TICKS));
   assign brk_stop = brk_flag;

   // Saturating tick count of the current break, so a long break never wraps.
   always_ff @(posedge i_clk) begin
      if (i_reset || st != S_BREAK) begin
         brk_cnt <= '0;
      end else if (bus.i_tick && !brk_full) begin
         brk_cnt <= brk_cnt + 1'b1;
      end
   end

   // Marks the stop period that closes a break: one stop bit, no done pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset || st_next == S_IDLE) begin
         brk_flag <= 1'b0;
      end else if (st == S_BREAK) begin
         brk_flag <= 1'b1;
      end
   end
`else
   logic unused_break;
   assign unused_break = bus.i_break;
   assign brk_req      = 1'b0;
   assign brk_stop     = 1'b0;
`endif

   assign tmr_last  = (st == S_STOP && stop2_q && !brk_stop) ? LAST_2 : LAST_1;
   // Held at 0 in IDLE and restarted on every state change.
   assign tmr_clear = (st == S_IDLE) || (st_next != st);

   uart_bit_timer #(
      .NB_TCNT (NB_TCNT)
   ) u_bit_timer (
      .clk     (i_clk),
      .reset   (i_reset),
      .tick    (bus.i_tick),
      .clear   (tmr_clear),
      .last    (tmr_last),
      .bit_end (bit_end)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         st <= S_IDLE;
      end else begin
         st <= st_next;
      end
   end

   always_comb begin
      st_next   = st;
      idx_next  = idx;
      accept    = 1'b0;
      done      = 1'b0;
      line_next = 1'b1;
      case (st)
         S_IDLE: begin
            if (brk_req) begin
               st_next = S_BREAK;
            end else if (bus.i_valid) begin
               accept  = 1'b1;
               st_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               st_next  = S_DATA;
               idx_next = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx == LAST_IDX) begin
                  idx_next = '0;
                  st_next  = par_en ? S_PARITY : S_STOP;
               end else begin
                  idx_next = idx + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               st_next = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               st_next = S_IDLE;
               done    = !brk_stop;
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            if (!bus.i_break && brk_full) begin
               st_next = S_STOP;
            end
         end
`endif
         default: begin
            st_next  = S_IDLE;
            idx_next = '0;
         end
      endcase

      // The line is registered, so it is driven from the state being entered.
      case (st_next)
         S_START, S_BREAK: line_next = 1'b0;
         S_DATA:           line_next = data_q[idx_next];
         S_PARITY:         line_next = par_bit;
         default:          line_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         idx     <= '0;
         line    <= 1'b1;
         data_q  <= '0;
         par_q   <= PAR_NONE;
         stop2_q <= 1'b0;
      end else begin
         idx  <= idx_next;
         line <= line_next;
         if (accept) begin
            data_q  <= bus.i_data;
            par_q   <= parity_e'(bus.i_parity);
            stop2_q <= bus.i_stop2;
         end
      end
   end

   assign bus.o_ready = (st == S_IDLE) && !brk_req;
   assign bus.o_data  = line;
   assign bus.o_done  = done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg with a frame scoreboard
module tb_uart_tx_cfg;
   localparam int NB   = 8;
   localparam int OS   = 16;
   localparam int TDIV = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_cfg_if #(.NB_DATA(NB)) bus ();

   uart_tx_cfg #(
      .NB_DATA    (NB),
      .OVERSAMPLE (OS)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      logic [NB-1:0] data;
      logic [1:0]    par;
      logic          stop2;
   } frame_t;

   frame_t sb[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int has_par(input frame_t f);
      return (f.par == 2'b01 || f.par == 2'b10) ? 1 : 0;
   endfunction

   function automatic int frame_ticks(input frame_t f);
      return OS * (1 + NB + has_par(f) + 1 + int'(f.stop2));
   endfunction

   // Expected line level per bit slot: start, data LSB first, parity, stop(s).
   function automatic logic [11:0] frame_line(input frame_t f);
      logic [11:0] v;
      int          j;
      v    = '0;
      v[0] = 1'b0;
      for (int i = 0; i < NB; i++) v[1 + i] = f.data[i];
      j = 1 + NB;
      if (has_par(f) != 0) begin
         v[j] = (^f.data) ^ (f.par == 2'b10);
         j++;
      end
      v[j] = 1'b1;
      if (f.stop2) v[j + 1] = 1'b1;
      return v;
   endfunction

   // Oversample tick: one clock wide, every TDIV clocks, always running.
   int tdiv = 0;
   initial begin
      bus.i_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tdiv       = (tdiv + 1) % TDIV;
         bus.i_tick = (tdiv == 0);
      end
   end

   // Line monitor: samples mid-bit, measures frame length, pops the scoreboard on done.
   int          mk        = 0;
   int          gap       = 0;
   int          n_acc     = 0;
   int          n_done    = 0;
   logic        in_frame  = 1'b0;
   logic        ready_chk = 1'b0;
   logic        b2b_mode  = 1'b0;
   logic        mon_en    = 1'b1;
   logic [11:0] obs;
   frame_t      mf;

   always @(negedge clk) begin
      if (rst) begin
         in_frame  = 1'b0;
         mk        = 0;
         gap       = 0;
         ready_chk = 1'b0;
         sb.delete();
      end else if (mon_en) begin
         if (ready_chk) begin
            check("ready_after_done", bus.o_ready, 1);
            ready_chk = 1'b0;
         end
         if (!in_frame && bus.o_data === 1'b0) begin
            in_frame = 1'b1;
            mk       = 0;
            obs      = '0;
            if (b2b_mode) check("b2b_gap_ticks", gap, 0);
         end
         if (bus.i_valid && bus.o_ready) n_acc++;
         if (bus.i_tick) begin
            if (in_frame) begin
               mk++;
               if (mk % OS == OS / 2 && mk / OS < 12) obs[mk / OS] = bus.o_data;
            end else begin
               gap++;
            end
         end
         if (bus.o_done === 1'b1) begin
            n_done++;
            check("done_in_frame", in_frame, 1);
            if (sb.size() == 0) begin
               check("scoreboard_nonempty", 0, 1);
            end else begin
               mf = sb.pop_front();
               check("frame_ticks", mk, frame_ticks(mf));
               check("frame_line", obs, frame_line(mf));
            end
            in_frame  = 1'b0;
            mk        = 0;
            gap       = 0;
            ready_chk = 1'b1;
         end
      end
   end

   task automatic send(input logic [NB-1:0] d, input logic [1:0] p, input logic s2, input logic hold);
      int     budget;
      frame_t f;
      bus.i_valid  = 1'b1;
      bus.i_data   = d;
      bus.i_parity = p;
      bus.i_stop2  = s2;
      budget = 0;
      while (bus.o_ready !== 1'b1 && budget < 4000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 4000) begin
         check("accept_timeout", 0, 1);
         bus.i_valid = 1'b0;
         return;
      end
      f.data  = d;
      f.par   = p;
      f.stop2 = s2;
      sb.push_back(f);
      @(posedge clk);
      #1;
      if (!hold) bus.i_valid = 1'b0;
      // Disturb the inputs after accept; the frame must use the latched copy.
      bus.i_data   = ~d;
      bus.i_parity = ~p;
      bus.i_stop2  = ~s2;
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while ((sb.size() != 0 || bus.o_ready !== 1'b1) && budget < 20000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 20000) check("idle_timeout", 0, 1);
   endtask

   int e_data, e_rdy, e_done;
   int a0, d0, budget;
   int lo, hi, tk, dn, rdy_err, acc;

   initial begin
      rst          = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_data   = '0;
      bus.i_parity = 2'b00;
      bus.i_stop2  = 1'b0;
      bus.i_break  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_o_data", bus.o_data, 1);
      check("reset_o_ready", bus.o_ready, 1);
      check("reset_o_done", bus.o_done, 0);
      rst = 1'b0;

      // Idle for 200 ticks: line mark, ready high, no done.
      e_data = 0; e_rdy = 0; e_done = 0;
      repeat (200 * TDIV) begin
         @(posedge clk);
         #1;
         if (bus.o_data !== 1'b1) e_data++;
         if (bus.o_ready !== 1'b1) e_rdy++;
         if (bus.o_done !== 1'b0) e_done++;
      end
      check("idle_line_errs", e_data, 0);
      check("idle_ready_errs", e_rdy, 0);
      check("idle_done_errs", e_done, 0);

      // 8N1 0xA5, even parity 0x07, odd parity 0x07 with two stop bits.
      send(8'hA5, 2'b00, 1'b0, 1'b0);
      wait_idle();
      send(8'h07, 2'b01, 1'b0, 1'b0);
      wait_idle();
      send(8'h07, 2'b10, 1'b1, 1'b0);
      wait_idle();

      // Back-to-back with valid held high; reserved parity code on the last word.
      a0 = n_acc;
      d0 = n_done;
      send(8'h00, 2'b00, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      b2b_mode = 1'b1;
      send(8'hFF, 2'b00, 1'b0, 1'b1);
      send(8'h3C, 2'b11, 1'b0, 1'b0);
      wait_idle();
      b2b_mode = 1'b0;
      check("b2b_accepts", n_acc - a0, 3);
      check("b2b_dones", n_done - d0, 3);

      // Reset during data bit 4, then a clean frame.
      send(8'h5A, 2'b00, 1'b0, 1'b0);
      budget = 0;
      while (!(in_frame && mk >= 5 * OS + OS / 2) && budget < 4000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("reach_bit4", budget < 4000, 1);
      check("ready_busy", bus.o_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_o_data", bus.o_data, 1);
      check("midreset_o_done", bus.o_done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midreset_o_ready", bus.o_ready, 1);
      send(8'hC3, 2'b10, 1'b0, 1'b0);
      wait_idle();

`ifdef UART_TX_BREAK_EN
      // Break pulsed for 10 ticks with a word offered the whole time.
      mon_en       = 1'b0;
      bus.i_break  = 1'b1;
      bus.i_valid  = 1'b1;
      bus.i_data   = 8'h55;
      bus.i_parity = 2'b00;
      bus.i_stop2  = 1'b0;
      lo = 0; hi = 0; tk = 0; dn = 0; rdy_err = 0; acc = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (bus.i_valid && bus.o_ready) acc++;
         if (bus.o_done === 1'b1) dn++;
         if (bus.i_tick) begin
            tk++;
            if (bus.o_data === 1'b0) lo++;
            else if (lo > 0 && bus.o_ready !== 1'b1) hi++;
         end
         if (lo > 0 && bus.o_data === 1'b0 && bus.o_ready !== 1'b0) rdy_err++;
         if (tk == 10) bus.i_break = 1'b0;
         if (lo > 0 && bus.o_data === 1'b1) bus.i_valid = 1'b0;
         if (lo > 0 && bus.o_data === 1'b1 && bus.o_ready === 1'b1) break;
      end
      check("break_low_ticks", lo, OS * (NB + 3));
      check("break_stop_ticks", hi, OS);
      check("break_no_done", dn, 0);
      check("break_no_accept", acc, 0);
      check("break_ready_low", rdy_err, 0);
      check("break_end_line", bus.o_data, 1);
      bus.i_break = 1'b0;
      bus.i_valid = 1'b0;
      mon_en      = 1'b1;
`endif

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter and successor to the fixed 8-bit, 2-stop serializer. Data width and oversampling are set at elaboration; parity mode and stop-bit count are selectable per frame. Uses a ready/valid input handshake and emits a frame-done pulse. Sits between the TX-side data source (ALU result path or FIFO) and the baud-rate tick generator, driving the serial line pin.

Parameters:
NB_DATA, 8, data bits per frame (5..9 supported)
OVERSAMPLE, 16, i_tick pulses per bit period (power of two not required, >=2)
NB_TCNT, derived localparam clog2(2*OVERSAMPLE), tick-counter width
BREAK_TICKS, derived localparam OVERSAMPLE*(NB_DATA+3), minimum break length in ticks

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  baud oversample strobe, one i_clk cycle wide
i_valid  in  1  source has a word
o_ready  out  1  block accepts a word this cycle
i_data  in  NB_DATA  word to send, LSB transmitted first
i_parity  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
i_stop2  in  1  0 = one stop bit, 1 = two stop bits
i_break  in  1  request break (used only with UART_TX_BREAK_EN)
o_data  out  1  serial line, registered, idle mark = 1
o_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: o_data=1, o_ready=1, o_done=0, state IDLE, counters 0, buffers 0. Reset mid-frame aborts immediately; line returns to 1 on the reset edge; partial frame is not resumed.
- Handshake: accept on an edge where i_valid && o_ready. i_data, i_parity, i_stop2 are latched at accept; later changes do not affect the frame. o_ready is 1 only in IDLE and falls on the accept edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (+ BREAK, optional).
- IDLE: o_data=1; ticks ignored; tick counter held at 0.
- START: o_data=0 from the cycle after accept; lasts exactly OVERSAMPLE ticks. Ticks on the accept edge are not counted.
- DATA: bit n = buffer[n], n = 0..NB_DATA-1; each bit lasts OVERSAMPLE ticks. After the last bit go to PARITY if mode is 01/10, else STOP.
- PARITY: even = XOR of the data bits; odd = its inverse; OVERSAMPLE ticks.
- STOP: o_data=1 for OVERSAMPLE*(1+stop2) ticks. On the final counted tick: o_done=1 for that cycle, next state IDLE, o_ready=1 the following cycle.
- Back-to-back: i_valid held high gives the next accept in the first IDLE cycle, so stop mark is followed directly by start. No extra idle ticks are inserted.
- Counter rule: the tick counter resets to 0 at each bit boundary, so there is no drift. Bit index width is clog2(NB_DATA). Tick counter never exceeds 2*OVERSAMPLE-1.
- Frame length in ticks: OVERSAMPLE*(1+NB_DATA+p+s), where p is 0 or 1 and s is 1 or 2.
- Illegal state encoding: recover to IDLE with o_data=1.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: in IDLE, i_break=1 has priority over i_valid and enters BREAK. o_ready=0 and o_data=0 in BREAK. BREAK exits when i_break=0 and at least BREAK_TICKS ticks have been counted. It then passes through STOP (one stop bit, o_done not asserted) before IDLE.
- Undefined: i_break ignored, BREAK state not built, break counter absent.

Decomposition:
- Package uart_pkg: parity encodings (PAR_NONE/EVEN/ODD), state localparams (one-hot, as in the existing transmitter), clog2 helper.
- Sub-module uart_bit_timer: counts i_tick up to a programmable limit and outputs a one-cycle bit_end strobe. It is cleared on state change and reused for the bit, stop and break periods.

Test Plan:
- Reset, then idle 200 ticks -> o_data=1, o_ready=1, o_done=0 throughout.
- 8N1, data 0xA5, OVERSAMPLE=16 -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; o_done after 160 ticks; o_ready high next cycle.
- Even parity 0x07, then odd parity 0x07 with i_stop2=1 -> parity bit 1 then 0; frame lengths 176 and 192 ticks.
- i_valid held high with words 0x00, 0xFF, 0x3C -> three frames with no gap between stop and start; exactly three accepts and three o_done pulses.
- Reset asserted during DATA bit 4 -> o_data=1 on the reset edge; o_ready=1 after reset; the next frame is transmitted correctly.
- UART_TX_BREAK_EN, i_break pulsed for 10 ticks -> line low for 176 ticks (NB_DATA=8), then 16 ticks high, then IDLE; i_valid is ignored during the break.
